// File: rtl/tcm_receiver_lane_packer_if.sv
// Pixel stream in, paired even/odd lane FIFO writes out.
// master = packer side, slave = sensor/FIFO side.
interface tcm_receiver_lane_packer_if #(
    parameter int unsigned C_PIXEL_WIDTH = 10
);
    logic                     fval;
    logic                     lval;
    logic                     dval;
    logic [C_PIXEL_WIDTH-1:0] pdata;
    logic                     full0;
    logic                     wren0;
    logic [11:0]              wdat0;
    logic                     full1;
    logic                     wren1;
    logic [11:0]              wdat1;

    modport master (
        input  fval, lval, dval, pdata, full0, full1,
        output wren0, wdat0, wren1, wdat1
    );

    modport slave (
        output fval, lval, dval, pdata, full0, full1,
        input  wren0, wdat0, wren1, wdat1
    );
endinterface

// File: rtl/tcm_receiver_lane_packer.sv
// Splits the sensor pixel stream into even/odd lane FIFO words, always writing
// both lanes as one pair. Word: bit11 SOF (lane0 only), bit10 EOL (lane1 only), 9:0 pixel.
module tcm_receiver_lane_packer #(
    parameter int unsigned C_PIXEL_WIDTH = 10,
    parameter logic [9:0]  C_PAD_VALUE   = 10'd0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    tcm_receiver_lane_packer_if.master        bus,
    output logic                              overflow,
    input  logic                              overflow_clr,
    output logic [15:0]                       line_width,
    output logic [15:0]                       frame_cnt
);
    localparam int unsigned PIX_W     = 10;
    localparam int unsigned WORD_W    = 12;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PIX_SHIFT = PIX_W - C_PIXEL_WIDTH;

    typedef enum logic [1:0] {IDLE, FRAME, LINE, DROP} state_t;

    state_t              state, state_nxt;
    logic                fval_q, lval_q;
    logic                sof_armed, sof_armed_nxt;
    logic [CNT_W-1:0]    pix_cnt, pix_cnt_nxt;
    logic                part_vld, part_vld_nxt;
    logic                part_sof, part_sof_nxt;
    logic [PIX_W-1:0]    part_dat, part_dat_nxt;
    logic                pend_vld, pend_vld_nxt;
    logic                pend_sof, pend_sof_nxt;
    logic [PIX_W-1:0]    pend_dat0, pend_dat0_nxt;
    logic [PIX_W-1:0]    pend_dat1, pend_dat1_nxt;
    logic                wren_q, wren_nxt;
    logic [WORD_W-1:0]   wdat0_q, wdat0_nxt;
    logic [WORD_W-1:0]   wdat1_q, wdat1_nxt;
    logic                overflow_nxt;
    logic [CNT_W-1:0]    line_width_nxt;
    logic [CNT_W-1:0]    frame_cnt_nxt;

    logic                fval_rise_c, fval_fall_c, lval_rise_c, lval_fall_c;
    logic                accept_c, full_c, ovf_set_c;
    logic [PIX_W-1:0]    pixel_c;

    assign fval_rise_c = bus.fval & ~fval_q;
    assign fval_fall_c = ~bus.fval & fval_q;
    assign lval_rise_c = bus.lval & ~lval_q;
    assign lval_fall_c = ~bus.lval & lval_q;
    assign accept_c    = bus.fval & bus.lval & bus.dval;
    assign full_c      = bus.full0 | bus.full1;
    // Narrow pixels are left-justified in the 10-bit field
    assign pixel_c     = PIX_W'(bus.pdata) << PIX_SHIFT;

    assign bus.wren0 = wren_q;
    assign bus.wren1 = wren_q;
    assign bus.wdat0 = wdat0_q;
    assign bus.wdat1 = wdat1_q;

    // Next-state, packing and pair-write decisions
    always_comb begin
        state_nxt      = state;
        sof_armed_nxt  = sof_armed;
        pix_cnt_nxt    = pix_cnt;
        part_vld_nxt   = part_vld;
        part_sof_nxt   = part_sof;
        part_dat_nxt   = part_dat;
        pend_vld_nxt   = pend_vld;
        pend_sof_nxt   = pend_sof;
        pend_dat0_nxt  = pend_dat0;
        pend_dat1_nxt  = pend_dat1;
        wren_nxt       = 1'b0;
        wdat0_nxt      = wdat0_q;
        wdat1_nxt      = wdat1_q;
        line_width_nxt = line_width;
        frame_cnt_nxt  = frame_cnt;
        ovf_set_c      = 1'b0;

        case (state)
            IDLE: begin
                if (fval_rise_c) begin
                    state_nxt     = FRAME;
                    sof_armed_nxt = 1'b1;
                end
            end
            FRAME: begin
                if (fval_fall_c) begin
                    state_nxt     = IDLE;
                    frame_cnt_nxt = frame_cnt + CNT_W'(1);
                end else if (lval_rise_c) begin
                    state_nxt    = LINE;
                    pix_cnt_nxt  = '0;
                    part_vld_nxt = 1'b0;
                    pend_vld_nxt = 1'b0;
                end
            end
            LINE: begin
                if (fval_fall_c || lval_fall_c) begin
                    line_width_nxt = pix_cnt;
                    part_vld_nxt   = 1'b0;
                    pend_vld_nxt   = 1'b0;
                    if (fval_fall_c) begin
                        state_nxt     = IDLE;
                        frame_cnt_nxt = frame_cnt + CNT_W'(1);
                    end else begin
                        state_nxt = FRAME;
                    end
                    if (part_vld || pend_vld) begin
                        if (full_c) begin
                            ovf_set_c = 1'b1;
                            // A frame that has already ended goes straight back to IDLE
                            if (!fval_fall_c) state_nxt = DROP;
                        end else if (part_vld) begin
                            wren_nxt  = 1'b1;
                            wdat0_nxt = {part_sof, 1'b0, part_dat};
                            wdat1_nxt = {2'b01, C_PAD_VALUE};
                        end else begin
                            wren_nxt  = 1'b1;
                            wdat0_nxt = {pend_sof, 1'b0, pend_dat0};
                            wdat1_nxt = {2'b01, pend_dat1};
                        end
                    end
                end else if (accept_c) begin
                    if (pix_cnt != '1) pix_cnt_nxt = pix_cnt + CNT_W'(1);
                    if (!part_vld) begin
                        if (pend_vld) begin
                            pend_vld_nxt = 1'b0;
                            if (full_c) begin
                                ovf_set_c = 1'b1;
                                state_nxt = DROP;
                            end else begin
                                wren_nxt  = 1'b1;
                                wdat0_nxt = {pend_sof, 1'b0, pend_dat0};
                                wdat1_nxt = {2'b00, pend_dat1};
                            end
                        end
                        part_vld_nxt  = 1'b1;
                        part_dat_nxt  = pixel_c;
                        part_sof_nxt  = sof_armed;
                        sof_armed_nxt = 1'b0;
                    end else begin
                        pend_vld_nxt  = 1'b1;
                        pend_sof_nxt  = part_sof;
                        pend_dat0_nxt = part_dat;
                        pend_dat1_nxt = pixel_c;
                        part_vld_nxt  = 1'b0;
                    end
                end
            end
            DROP: begin
                if (fval_fall_c) begin
                    state_nxt     = IDLE;
                    frame_cnt_nxt = frame_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        overflow_nxt = overflow_clr ? 1'b0 : (overflow | ovf_set_c);
    end

    // Edge history resets high so a frame already in progress is not seen as a rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fval_q     <= 1'b1;
            lval_q     <= 1'b1;
            sof_armed  <= 1'b0;
            pix_cnt    <= '0;
            part_vld   <= 1'b0;
            part_sof   <= 1'b0;
            part_dat   <= '0;
            pend_vld   <= 1'b0;
            pend_sof   <= 1'b0;
            pend_dat0  <= '0;
            pend_dat1  <= '0;
            wren_q     <= 1'b0;
            wdat0_q    <= '0;
            wdat1_q    <= '0;
            overflow   <= 1'b0;
            line_width <= '0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            fval_q     <= bus.fval;
            lval_q     <= bus.lval;
            sof_armed  <= sof_armed_nxt;
            pix_cnt    <= pix_cnt_nxt;
            part_vld   <= part_vld_nxt;
            part_sof   <= part_sof_nxt;
            part_dat   <= part_dat_nxt;
            pend_vld   <= pend_vld_nxt;
            pend_sof   <= pend_sof_nxt;
            pend_dat0  <= pend_dat0_nxt;
            pend_dat1  <= pend_dat1_nxt;
            wren_q     <= wren_nxt;
            wdat0_q    <= wdat0_nxt;
            wdat1_q    <= wdat1_nxt;
            overflow   <= overflow_nxt;
            line_width <= line_width_nxt;
            frame_cnt  <= frame_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_tcm_receiver_lane_packer.sv
// Directed bench for tcm_receiver_lane_packer: 10-bit and 8-bit instances,
// lane writes captured into queues and compared against hand-computed words.
module tb_tcm_receiver_lane_packer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tcm_receiver_lane_packer_if #(.C_PIXEL_WIDTH(10)) bus10 ();
    tcm_receiver_lane_packer_if #(.C_PIXEL_WIDTH(8))  bus8 ();

    logic        ovf10, ovf_clr10, ovf8, ovf_clr8;
    logic [15:0] lw10, fc10, lw8, fc8;

    tcm_receiver_lane_packer #(.C_PIXEL_WIDTH(10), .C_PAD_VALUE(10'd0)) u_dut10 (
        .clk(clk), .reset_n(reset_n), .bus(bus10),
        .overflow(ovf10), .overflow_clr(ovf_clr10),
        .line_width(lw10), .frame_cnt(fc10)
    );

    tcm_receiver_lane_packer #(.C_PIXEL_WIDTH(8), .C_PAD_VALUE(10'd0)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8),
        .overflow(ovf8), .overflow_clr(ovf_clr8),
        .line_width(lw8), .frame_cnt(fc8)
    );

    int errors = 0;
    int checks = 0;
    bit use8 = 1'b0;
    logic [11:0] q0[$], q1[$], r0[$], r1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of sensor input, then log any lane writes
    task automatic cyc(input logic f, input logic l, input logic d, input logic [9:0] px);
        if (use8) begin
            bus8.fval = f; bus8.lval = l; bus8.dval = d; bus8.pdata = px[7:0];
        end else begin
            bus10.fval = f; bus10.lval = l; bus10.dval = d; bus10.pdata = px;
        end
        @(posedge clk);
        #1;
        if (bus10.wren0) q0.push_back(bus10.wdat0);
        if (bus10.wren1) q1.push_back(bus10.wdat1);
        if (bus8.wren0)  r0.push_back(bus8.wdat0);
        if (bus8.wren1)  r1.push_back(bus8.wdat1);
    endtask

    task automatic send_line(input logic [9:0] base, input int n);
        cyc(1'b1, 1'b1, 1'b0, 10'h0);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, base + 10'(i));
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 10'h0);
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); r0.delete(); r1.delete();
    endtask

    initial begin
        bus10.fval = 0; bus10.lval = 0; bus10.dval = 0; bus10.pdata = '0;
        bus10.full0 = 0; bus10.full1 = 0;
        bus8.fval = 0; bus8.lval = 0; bus8.dval = 0; bus8.pdata = '0;
        bus8.full0 = 0; bus8.full1 = 0;
        ovf_clr10 = 0; ovf_clr8 = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_wren0", 32'(bus10.wren0), 32'h0);
        check("rst_wren1", 32'(bus10.wren1), 32'h0);
        check("rst_ovf", 32'(ovf10), 32'h0);
        check("rst_lw", 32'(lw10), 32'h0);
        check("rst_fc", 32'(fc10), 32'h0);
        reset_n = 1'b1;
        idle(2);
        clear_q();

        // 4-pixel line
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        send_line(10'h001, 4);
        idle(2);
        check("l4_n0", 32'(q0.size()), 32'd2);
        check("l4_n1", 32'(q1.size()), 32'd2);
        check("l4_w0a", 32'(q0[0]), 32'h801);
        check("l4_w0b", 32'(q0[1]), 32'h003);
        check("l4_w1a", 32'(q1[0]), 32'h002);
        check("l4_w1b", 32'(q1[1]), 32'h404);
        check("l4_lw", 32'(lw10), 32'd4);
        check("l4_fc", 32'(fc10), 32'd1);
        clear_q();

        // 3-pixel line, odd count padded
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        send_line(10'h010, 3);
        idle(2);
        check("l3_n0", 32'(q0.size()), 32'd2);
        check("l3_w0a", 32'(q0[0]), 32'h810);
        check("l3_w0b", 32'(q0[1]), 32'h012);
        check("l3_w1a", 32'(q1[0]), 32'h011);
        check("l3_w1b", 32'(q1[1]), 32'h400);
        check("l3_lw", 32'(lw10), 32'd3);
        check("l3_fc", 32'(fc10), 32'd2);
        clear_q();

        // 8-bit instance, single pixel 0xFF
        use8 = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        send_line(10'h0FF, 1);
        idle(2);
        use8 = 1'b0;
        check("p8_n0", 32'(r0.size()), 32'd1);
        check("p8_n1", 32'(r1.size()), 32'd1);
        check("p8_w0", 32'(r0[0]), 32'hBFC);
        check("p8_w1", 32'(r1[0]), 32'h400);
        check("p8_lw", 32'(lw8), 32'd1);
        check("p8_fc", 32'(fc8), 32'd1);
        check("p8_idle10", 32'(q0.size()), 32'd0);
        clear_q();

        // Overflow on the second pair of a 6-pixel line
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        cyc(1'b1, 1'b1, 1'b0, 10'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 10'h020 + 10'(i));
        bus10.full1 = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 10'h024);
        bus10.full1 = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 10'h025);
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        cyc(1'b1, 1'b1, 1'b1, 10'h026);
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        idle(2);
        check("ov_n0", 32'(q0.size()), 32'd1);
        check("ov_n1", 32'(q1.size()), 32'd1);
        check("ov_w0", 32'(q0[0]), 32'h820);
        check("ov_w1", 32'(q1[0]), 32'h021);
        check("ov_flag", 32'(ovf10), 32'h1);
        check("ov_fc", 32'(fc10), 32'd3);
        clear_q();

        // Next frame packs normally; overflow stays sticky until cleared
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        send_line(10'h030, 2);
        idle(2);
        check("ov_nx_n0", 32'(q0.size()), 32'd1);
        check("ov_nx_w0", 32'(q0[0]), 32'h830);
        check("ov_nx_w1", 32'(q1[0]), 32'h431);
        check("ov_sticky", 32'(ovf10), 32'h1);
        ovf_clr10 = 1'b1;
        idle(1);
        ovf_clr10 = 1'b0;
        check("ov_clr", 32'(ovf10), 32'h0);
        check("ov_nx_fc", 32'(fc10), 32'd4);
        clear_q();

        // fval falls with lval still high after 2 pixels
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        cyc(1'b1, 1'b1, 1'b0, 10'h0);
        cyc(1'b1, 1'b1, 1'b1, 10'h040);
        cyc(1'b1, 1'b1, 1'b1, 10'h041);
        cyc(1'b0, 1'b1, 1'b0, 10'h0);
        idle(2);
        check("ff_n0", 32'(q0.size()), 32'd1);
        check("ff_w0", 32'(q0[0]), 32'h840);
        check("ff_w1", 32'(q1[0]), 32'h441);
        check("ff_lw", 32'(lw10), 32'd2);
        check("ff_fc", 32'(fc10), 32'd5);
        clear_q();

        // Reset pulsed mid-line while a write is on the bus
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        cyc(1'b1, 1'b1, 1'b0, 10'h0);
        cyc(1'b1, 1'b1, 1'b1, 10'h050);
        cyc(1'b1, 1'b1, 1'b1, 10'h051);
        cyc(1'b1, 1'b1, 1'b1, 10'h052);
        check("rm_pre_wren", 32'(bus10.wren0), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rm_wren0", 32'(bus10.wren0), 32'h0);
        check("rm_wren1", 32'(bus10.wren1), 32'h0);
        clear_q();
        cyc(1'b1, 1'b1, 1'b1, 10'h053);
        reset_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 10'h054);
        cyc(1'b1, 1'b1, 1'b1, 10'h055);
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        cyc(1'b1, 1'b1, 1'b1, 10'h056);
        cyc(1'b1, 1'b1, 1'b1, 10'h057);
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        idle(2);
        check("rm_quiet", 32'(q0.size()), 32'd0);
        check("rm_fc0", 32'(fc10), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 10'h0);
        send_line(10'h060, 2);
        idle(2);
        check("rm_n0", 32'(q0.size()), 32'd1);
        check("rm_sof", 32'(q0[0]), 32'h860);
        check("rm_w1", 32'(q1[0]), 32'h461);
        check("rm_fc1", 32'(fc10), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tcm_receiver_lane_packer.md
Name: tcm_receiver_lane_packer

Overview:
- Upstream stage of the TCM receiver AXIS interface.
- Takes the sensor's parallel pixel stream (fval/lval/dval/pdata) in the clk domain and splits it into even/odd lane FIFOs (lane0 = even pixels, lane1 = odd pixels).
- Each FIFO word is 12 bits: bit11 = SOF, bit10 = EOL, bits 9:0 = pixel. SOF is only ever on lane0; EOL is only ever on lane1.
- Always writes both lanes as a pair, so the downstream parity reader can never desynchronise.

Parameters:
- C_PIXEL_WIDTH, 10: input pixel width, 8 or 10. An 8-bit pixel is placed in word bits 9:2, with bits 1:0 set to 0.
- C_PAD_VALUE, 0: 10-bit pixel field value written to lane1 when a line has an odd pixel count.

Ports:
- clk  in  1  pixel/system clock
- reset_n  in  1  asynchronous active-low reset
- fval  in  1  frame valid
- lval  in  1  line valid
- dval  in  1  pixel data valid; a pixel is accepted when fval & lval & dval
- pdata  in  C_PIXEL_WIDTH  pixel data
- full0  in  1  lane0 FIFO full
- wren0  out  1  lane0 write enable
- wdat0  out  12  lane0 write data
- full1  in  1  lane1 FIFO full
- wren1  out  1  lane1 write enable
- wdat1  out  12  lane1 write data
- overflow  out  1  sticky overflow flag; a pair was dropped
- overflow_clr  in  1  clears overflow (synchronous)
- line_width  out  16  unpadded pixel count of the last completed line
- frame_cnt  out  16  count of completed frames; wraps from 0xFFFF to 0

Behaviour:
- Reset (async assert, sync deassert by design): all outputs 0, state IDLE, holding registers empty, SOF flag clear.
- Edge detection uses registered fval/lval. Rise/fall events are evaluated in the cycle the input changes, using the previous-cycle value.
- States:
  - IDLE: fval rise -> FRAME, SOF flag armed. If lval/fval are already high out of reset, the partial frame is ignored until the next fval rise.
  - FRAME: lval rise -> LINE, pixel counter = 0, partial and pending cleared. fval fall -> IDLE, frame_cnt+1.
  - LINE: accepted pixels are packed as below. lval fall -> line end, then FRAME. fval fall while lval is high -> line end, then IDLE, frame_cnt+1.
  - DROP: entered on overflow. No writes. fval fall -> IDLE, frame_cnt+1. A new fval rise re-arms only via IDLE.
- Packing in LINE, for each accepted pixel:
  - Even index: if a pending pair exists, write it with EOL=0. The pixel goes to the partial register and carries SOF = armed flag; the flag clears once it is consumed by a pixel.
  - Odd index: {partial, pixel} becomes the pending pair; the partial register is cleared.
- Line end:
  - Partial present: write {partial, C_PAD_VALUE} with EOL=1.
  - Otherwise, pending present: write the pending pair with EOL=1.
  - Otherwise (zero-pixel line): no write.
  - line_width <= pixel counter, updated on every line end, including zero-length lines.
- Write rules:
  - A write asserts wren0 and wren1 together for exactly one cycle, registered in the cycle after the triggering event.
  - wdat0 = {SOF, 1'b0, even pixel}; wdat1 = {1'b0, EOL, odd pixel}.
  - At most one pair write per cycle; the triggering events guarantee this.
- Overflow:
  - Check full0 | full1 in the cycle of the event. If set: no write, the pair is dropped, overflow <= 1, state -> DROP.
  - overflow_clr has priority over a same-cycle set.
- Pixel counter: 16-bit, saturates at 0xFFFF.
- dval low inside a line inserts gaps; it has no other effect.

Test Plan:
- 4-pixel line (0x001..0x004) in one frame -> two pair writes: lane0 0x801, 0x003; lane1 0x002, 0x404. line_width=4, frame_cnt=1.
- 3-pixel line (0x010..0x012), C_PAD_VALUE=0 -> lane0 0x810, 0x012; lane1 0x011, 0x400. line_width=3.
- C_PIXEL_WIDTH=8, pixel 0xFF as the only pixel of a frame -> lane0 0xBFC, lane1 0x400.
- full1 high during the second pair of a 6-pixel line -> only the first pair is written; overflow=1; no writes until the next frame; the next frame is packed normally. overflow_clr -> 0.
- fval falls with lval still high after 2 pixels -> one write with EOL on lane1; state IDLE; frame_cnt increments.
- reset_n pulsed low mid-line -> wren0/wren1 drop to 0 immediately. After release, no writes until a fresh fval rise. The first pixel after that carries SOF.
